// File: rtl/cordic_rot_seq.sv
// Rotation-mode CORDIC iteration sequencer driving an external arctangent table.
// Optional macro CORDIC_GAIN_COMP_EN adds a GAIN state that scales the result by K.
module cordic_rot_seq #(
  parameter int ITERS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  input  logic [31:0] angle_in,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] x_out,
  output logic [31:0] y_out,
  output logic [31:0] z_out,
  output logic        lut_en,
  output logic [3:0]  lut_sel,
  input  logic [31:0] lut_value,
  output logic [2:0]  dbg_state
);

  // Handshake: start is taken on a rising edge only while ready=1 (IDLE);
  // the result is valid while done=1 and x_out/y_out/z_out hold until the next done.
  typedef enum logic [2:0] {
    INIT = 3'd0,
    IDLE = 3'd1,
    RUN  = 3'd2,
`ifdef CORDIC_GAIN_COMP_EN
    GAIN = 3'd3,
`endif
    DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic signed [31:0] x_r, y_r, z_r;
  logic [3:0]         i_r;
  logic               err_r;
  logic               lut_en_r;
  logic [3:0]         lut_sel_r;

  logic load, reject, step, last, out_of_range;
  logic d_pos;
  logic signed [31:0] xs, ys, x_nxt, y_nxt, z_nxt;

  assign out_of_range = ($signed(angle_in) > 32'sh5A000000) ||
                        ($signed(angle_in) < -32'sh5A000000);
  assign last = (i_r == 4'(ITERS - 1));

  // One micro-rotation: direction chosen by the sign of the residual angle.
  assign d_pos = ~z_r[31];
  assign xs    = x_r >>> i_r;
  assign ys    = y_r >>> i_r;
  assign x_nxt = d_pos ? (x_r - ys) : (x_r + ys);
  assign y_nxt = d_pos ? (y_r + xs) : (y_r - xs);
  assign z_nxt = d_pos ? (z_r - $signed(lut_value)) : (z_r + $signed(lut_value));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    load      = 1'b0;
    reject    = 1'b0;
    step      = 1'b0;
    case (state)
      INIT: if (lut_en_r) state_nxt = IDLE;
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          if (out_of_range) begin
            reject    = 1'b1;
            state_nxt = DONE;
          end else begin
            load      = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        step = 1'b1;
`ifdef CORDIC_GAIN_COMP_EN
        if (last) state_nxt = GAIN;
`else
        if (last) state_nxt = DONE;
`endif
      end
`ifdef CORDIC_GAIN_COMP_EN
      GAIN: state_nxt = DONE;
`endif
      DONE: begin
        done      = 1'b1;
        err       = err_r;
        state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [31:0] K_GAIN = 32'sh26DD3B6A;
  logic signed [63:0] px, py;
  assign px = x_r * K_GAIN;
  assign py = y_r * K_GAIN;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      i_r       <= '0;
      err_r     <= 1'b0;
      lut_en_r  <= 1'b0;
      lut_sel_r <= '0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
    end else begin
      // Single arm pulse: INIT waits here until the strobe has been seen once.
      lut_en_r <= (state == INIT) && !lut_en_r;
      if (load) begin
        x_r       <= $signed(x_in);
        y_r       <= $signed(y_in);
        z_r       <= $signed(angle_in);
        i_r       <= '0;
        lut_sel_r <= '0;
        err_r     <= 1'b0;
      end
      if (reject) err_r <= 1'b1;
      if (step) begin
        x_r <= x_nxt;
        y_r <= y_nxt;
        z_r <= z_nxt;
        i_r <= i_r + 4'd1;
        if (!last) lut_sel_r <= i_r + 4'd1;
`ifndef CORDIC_GAIN_COMP_EN
        if (last) begin
          x_out <= x_nxt;
          y_out <= y_nxt;
          z_out <= z_nxt;
        end
`endif
      end
`ifdef CORDIC_GAIN_COMP_EN
      if (state == GAIN) begin
        x_out <= 32'(px >>> 30);
        y_out <= 32'(py >>> 30);
        z_out <= z_r;
      end
`endif
    end
  end

  assign lut_en    = lut_en_r;
  assign lut_sel   = lut_sel_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_cordic_rot_seq.sv
// Directed bench for cordic_rot_seq: reset/arm, rotations, range errors, back-to-back, mid-run reset.
// Expected values follow CORDIC_GAIN_COMP_EN the same way the design does.
module tb_cordic_rot_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] x_in, y_in, angle_in;
  logic        ready, done, err, lut_en;
  logic [31:0] x_out, y_out, z_out;
  logic [3:0]  lut_sel;
  logic [31:0] lut_value;
  logic [2:0]  dbg_state;

  logic [31:0] lut_tbl [16];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  real         kg;
  real         g;
  int          lat;

  localparam real PI = 3.14159265358979;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 16;
`endif

  always #5 clk = ~clk;

  assign lut_value = lut_tbl[lut_sel];

  cordic_rot_seq #(.ITERS(15)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_in(x_in), .y_in(y_in), .angle_in(angle_in),
    .ready(ready), .done(done), .err(err),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .lut_en(lut_en), .lut_sel(lut_sel), .lut_value(lut_value),
    .dbg_state(dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                         input int tol);
    int d;
    d = $signed(obs) - $signed(exp);
    if (d < 0) d = -d;
    n_chk++;
    assert (d <= tol) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h +/- %h", tag, obs, exp, tol);
    end
  endtask

  function automatic logic [31:0] q30(input real v);
    return 32'($rtoi(v * 1073741824.0));
  endfunction

  task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] a);
    x_in = x; y_in = y; angle_in = a; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called just after the accepting edge; lat counts clocks from that edge to done.
  task automatic wait_done(input bit pulse, output int lat_o);
    int cyc;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      if (pulse && (cyc == 3 || cyc == 8)) begin
        start = 1'b1; x_in = $urandom; y_in = $urandom;
        angle_in = 32'($urandom_range(32'h10000000, 0));
      end else start = 1'b0;
      step();
      cyc++;
    end
    start = 1'b0;
    lat_o = cyc;
  endtask

  task automatic chk_rot30(input string tag);
`ifdef CORDIC_GAIN_COMP_EN
    chk_tol({tag, "_x"}, x_out, 32'h376CF5D1, 32'h10000);
    chk_tol({tag, "_y"}, y_out, 32'h20000000, 32'h10000);
`else
    chk_tol({tag, "_x"}, x_out, q30(0.8660254038 * kg), 32'h40000);
    chk_tol({tag, "_y"}, y_out, q30(0.5 * kg), 32'h40000);
`endif
    chk_tol({tag, "_z"}, z_out, 32'h0, 32'hE557);
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      lut_tbl[i] = 32'($rtoi($atan($pow(2.0, -i)) * 180.0 / PI * 16777216.0 + 0.5));
    kg = 1.0;
    for (int i = 0; i < 15; i++) kg = kg * $sqrt(1.0 + $pow(4.0, -i));
`ifdef CORDIC_GAIN_COMP_EN
    g = 1.0;
`else
    g = kg;
`endif

    rst = 1'b1; start = 1'b0; x_in = '0; y_in = '0; angle_in = '0;
    repeat (3) step();
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_lut_en", lut_en, 0);
    chk("rst_lut_sel", lut_sel, 0);
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_z", z_out, 0);
    chk("rst_state", dbg_state, 0);

    rst = 1'b0;
    step();
    chk("arm_lut_en", lut_en, 1);
    chk("arm_ready", ready, 0);
    step();
    chk("idle_lut_en", lut_en, 0);
    chk("idle_ready", ready, 1);

    // 30 degrees with start pulsed during RUN.
    launch(32'h40000000, 32'h0, 32'h1E000000);
    chk("r30_ready_drop", ready, 0);
    wait_done(1'b1, lat);
    chk("r30_latency", lat, LAT);
    chk("r30_err", err, 0);
    chk_rot30("r30");

    // Back-to-back request raised in the done cycle, accepted in the first IDLE cycle.
    x_in = 32'h20000000; y_in = 32'h0; angle_in = 32'h0; start = 1'b1;
    step();
    chk("b2b_ready_back", ready, 1);
    chk("b2b_done_low", done, 0);
    step();
    start = 1'b0;
    chk("b2b_accepted", ready, 0);
    wait_done(1'b0, lat);
    chk("b2b_latency", lat, LAT);
    chk_tol("b2b_x", x_out, q30(0.5 * g), 32'h10000);
    chk_tol("b2b_y", y_out, 32'h0, 32'h20000);
    chk_tol("b2b_z", z_out, 32'h0, 32'hE557);
    step();

    // +91 degrees: immediate error, outputs hold the previous result.
    launch(32'h11111111, 32'h22222222, 32'h5B000000);
    chk("p91_done", done, 1);
    chk("p91_err", err, 1);
    chk_tol("p91_x_held", x_out, q30(0.5 * g), 32'h10000);
    chk_tol("p91_y_held", y_out, 32'h0, 32'h20000);
    chk_tol("p91_z_held", z_out, 32'h0, 32'hE557);
    step();
    chk("p91_done_pulse", done, 0);
    chk("p91_err_pulse", err, 0);
    chk("p91_ready_back", ready, 1);

    // -91 degrees.
    launch(32'h40000000, 32'h0, 32'hA5000000);
    chk("m91_err", err, 1);
    chk("m91_done", done, 1);
    step();

    // Exactly +90 and -90 degrees are in range.
    launch(32'h40000000, 32'h0, 32'h5A000000);
    chk("p90_accepted", ready, 0);
    chk("p90_no_early_done", done, 0);
    wait_done(1'b0, lat);
    chk("p90_latency", lat, LAT);
    chk("p90_err", err, 0);
    chk_tol("p90_x", x_out, 32'h0, 32'h40000);
    chk_tol("p90_y", y_out, q30(g), 32'h40000);
    step();
    launch(32'h40000000, 32'h0, 32'hA6000000);
    wait_done(1'b0, lat);
    chk("m90_latency", lat, LAT);
    chk_tol("m90_x", x_out, 32'h0, 32'h40000);
    chk_tol("m90_y", y_out, q30(-g), 32'h40000);
    step();

    // Reset after seven iterations.
    launch(32'h40000000, 32'h0, 32'h1E000000);
    repeat (7) step();
    chk("mid_lut_sel", lut_sel, 7);
    rst = 1'b1;
    #1;
    chk("mid_rst_x", x_out, 0);
    chk("mid_rst_y", y_out, 0);
    chk("mid_rst_z", z_out, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_lut_en", lut_en, 0);
    step();
    rst = 1'b0;
    step();
    chk("rearm_lut_en", lut_en, 1);
    step();
    chk("rearm_idle_lut_en", lut_en, 0);
    chk("rearm_ready", ready, 1);
    launch(32'h40000000, 32'h0, 32'h1E000000);
    wait_done(1'b0, lat);
    chk("post_rst_latency", lat, LAT);
    chk_rot30("post_rst");
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
